// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: opcodes, instruction fields,
// register-file geometry and the result-slot state encoding.
package alu_pkg;
    localparam int OP_W     = 3;
    localparam int RA_W     = 2;
    localparam int INSTR_W  = 9;
    localparam int OPC_LSB  = 6;
    localparam int DST_LSB  = 4;
    localparam int SRCA_LSB = 2;
    localparam int SRCB_LSB = 0;
    localparam int NUM_REGS = 4;
    localparam int REG_W    = 4;
    localparam int RES_W    = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd2;
    localparam logic [OP_W-1:0] OP_AND  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_NAND = 3'd5;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd7;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    // Only the arithmetic ops carry a meaningful carry flag.
    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction
endpackage

// File: rtl/alu_instr_fifo.sv
// Synchronous instruction FIFO; pointers wrap naturally at DEPTH (power of 2).
module alu_instr_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [INSTR_W-1:0]         i_din,
    input  logic                       i_pop,
    output logic [INSTR_W-1:0]         o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage: buffers instructions, drives the combinational ALU from the
// register file, captures its result into a one-entry slot and writes back.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                ld_en,
    input  logic [RA_W-1:0]     ld_addr,
    input  logic [REG_W-1:0]    ld_data,
    output logic [OP_W-1:0]     alu_code,
    output logic [REG_W-1:0]    alu_a,
    output logic [REG_W-1:0]    alu_b,
    input  logic [RES_W-1:0]    alu_result,
    input  logic                alu_flag_c,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RES_W-1:0]    res_data,
    output logic                res_flag_c,
    output logic [RA_W-1:0]     res_dst,
    output logic [7:0]          retired
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

    logic [INSTR_W-1:0] w_head;
    logic [AW:0]        w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_exec;
    logic [OP_W-1:0]    w_op;
    logic [RA_W-1:0]    w_dst;
    logic [RA_W-1:0]    w_srca;
    logic [RA_W-1:0]    w_srcb;

    logic [REG_W-1:0]   r_regs [NUM_REGS];
    slot_state_t        r_state;
    slot_state_t        w_state_nxt;
    logic [RES_W-1:0]   r_res_data;
    logic               r_res_flag_c;
    logic [RA_W-1:0]    r_res_dst;
    logic [7:0]         r_retired;

    assign instr_ready = (w_count < CNT_DEPTH);
    // Ready is just "not full"; gate with the FIFO's own flag.
    assign w_push      = instr_valid && !w_full;
    assign res_valid   = (r_state == S_FULL);
    assign w_exec      = !w_empty && (!res_valid || res_ready);

    assign w_op   = w_head[OPC_LSB  +: OP_W];
    assign w_dst  = w_head[DST_LSB  +: RA_W];
    assign w_srca = w_head[SRCA_LSB +: RA_W];
    assign w_srcb = w_head[SRCB_LSB +: RA_W];

    assign res_data   = r_res_data;
    assign res_flag_c = r_res_flag_c;
    assign res_dst    = r_res_dst;
    assign retired    = r_retired;

    alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (instr),
        .i_pop   (w_exec),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ALU drive: head instruction during an exec cycle, zeros otherwise.
    always_comb begin
        alu_code = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (w_exec) begin
            alu_code = w_op;
            alu_a    = r_regs[w_srca];
            alu_b    = r_regs[w_srcb];
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Slot next state: fill on exec, drain when consumed with nothing new.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_exec) w_state_nxt = S_FULL;
            S_FULL:  if (w_exec) w_state_nxt = S_FULL;
                     else if (res_ready) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Result capture and retire count; held untouched while backpressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data   <= '0;
            r_res_flag_c <= 1'b0;
            r_res_dst    <= '0;
            r_retired    <= '0;
        end else if (w_exec) begin
            r_res_data   <= alu_result;
            r_res_flag_c <= op_has_carry(w_op) ? alu_flag_c : 1'b0;
            r_res_dst    <= w_dst;
            r_retired    <= r_retired + 8'd1;
        end
    end

    // Register file: direct load takes priority over a same-edge writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ld_en && (ld_addr == RA_W'(i)))
                    r_regs[i] <= ld_data;
                else if (w_exec && (w_dst == RA_W'(i)))
                    r_regs[i] <= alu_result[REG_W-1:0];
            end
        end
    end
endmodule
